// File: rtl/hash_stream_core.sv
`timescale 1ns/1ps
// hash_stream_core: byte-serial hash. Each message byte is mixed into a
// DIGEST_W-bit chaining value over ROUNDS rotate/add rounds. The byte count
// is then absorbed as LEN_W/8 padding bytes before the digest is released.
module hash_stream_core #(
  parameter int                  DIGEST_W = 32,
  parameter int                  LEN_W    = 64,
  parameter int                  ROUNDS   = 8,
  parameter logic [DIGEST_W-1:0] IV       = DIGEST_W'(32'h3B6A2F91)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [LEN_W-1:0]    len_in,
  input  logic                msg_valid,
  input  logic [7:0]          msg_byte,
  input  logic                msg_last,
  output logic                msg_ready,
  output logic                busy,
  output logic [DIGEST_W-1:0] digest,
  output logic                digest_valid,
  output logic                hash_err
);

  localparam int         N        = DIGEST_W / 8;
  localparam int         P        = LEN_W / 8;
  localparam logic [7:0] R_LAST   = 8'(ROUNDS - 1);
  localparam logic [2:0] PAD_LAST = 3'(P - 1);

  typedef enum logic [2:0] {IDLE, ABSORB, ROUND, PAD, DONE} state_e;

  // Rotate an 8-bit lane left by s positions.
  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] s);
    logic [15:0] d;
    d = {x, x} << s;
    return d[15:8];
  endfunction

  // One round over all lanes at once. Every lane reads the old value of h.
  function automatic logic [DIGEST_W-1:0] round_fn(input logic [DIGEST_W-1:0] h,
                                                   input logic [7:0]          b,
                                                   input logic [7:0]          r);
    logic [DIGEST_W-1:0] res;
    logic [7:0]          t;
    t   = b ^ r;
    res = '0;
    for (int j = 0; j < N; j++) begin
      res[8*j +: 8] = rotl8(h[8*((j+1)%N) +: 8] ^ t, 3'(j) + r[2:0]) + h[8*j +: 8];
    end
    return res;
  endfunction

  state_e              state_q, state_d;
  logic [DIGEST_W-1:0] h_q, h_d;
  logic [DIGEST_W-1:0] digest_q, digest_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [7:0]          b_q, b_d;
  logic [7:0]          r_q, r_d;
  logic [2:0]          pad_idx_q, pad_idx_d;
  logic                final_q, final_d;
  logic                digest_valid_q, digest_valid_d;
  logic                hash_err_q, hash_err_d;
  logic                msg_ready_q, msg_ready_d;
  logic                busy_q, busy_d;

  logic [LEN_W-1:0]    cnt_inc;
  logic [LEN_W-1:0]    pad_shift;
  logic [7:0]          round_byte;
  logic [DIGEST_W-1:0] h_round;
  logic                len_hit;

  // Round datapath: message byte in ROUND, selected byte of cnt in PAD.
  always_comb begin
    cnt_inc    = cnt_q + LEN_W'(1);
    len_hit    = (cnt_inc == len_q);
    pad_shift  = cnt_q >> {pad_idx_q, 3'b000};
    round_byte = (state_q == PAD) ? pad_shift[7:0] : b_q;
    h_round    = round_fn(h_q, round_byte, r_q);
  end

  // Next-state and next-value logic for the whole FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d        = state_q;
    h_d            = h_q;
    digest_d       = digest_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    b_d            = b_q;
    r_d            = r_q;
    pad_idx_d      = pad_idx_q;
    final_d        = final_q;
    digest_valid_d = 1'b0;
    hash_err_d     = hash_err_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          h_d        = IV;
          cnt_d      = '0;
          len_d      = len_in;
          r_d        = '0;
          pad_idx_d  = '0;
          final_d    = 1'b0;
          hash_err_d = 1'b0;
          state_d    = (len_in == '0) ? PAD : ABSORB;
        end
      end
      ABSORB: begin
        if (msg_valid && msg_ready_q) begin
          b_d     = msg_byte;
          cnt_d   = cnt_inc;
          r_d     = '0;
          final_d = msg_last | len_hit;
          // Only one of the two end conditions firing means the length lied.
          hash_err_d = hash_err_q | (msg_last ^ len_hit);
          state_d    = ROUND;
        end
      end
      ROUND: begin
        h_d = h_round;
        r_d = r_q + 8'd1;
        if (r_q == R_LAST) begin
          r_d       = '0;
          pad_idx_d = '0;
          state_d   = final_q ? PAD : ABSORB;
        end
      end
      PAD: begin
        h_d = h_round;
        r_d = r_q + 8'd1;
        if (r_q == R_LAST) begin
          r_d = '0;
          if (pad_idx_q == PAD_LAST) begin
            digest_d       = h_round;
            digest_valid_d = 1'b1;
            state_d        = DONE;
          end else begin
            pad_idx_d = pad_idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    msg_ready_d = (state_d == ABSORB);
    busy_d      = (state_d == ABSORB) || (state_d == ROUND) || (state_d == PAD);
  end

  // State register; outputs are registered copies decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the chaining value and digest are reset too, so no stale hash is visible after an abort.
    if (!rst_n) begin
      state_q        <= IDLE;
      h_q            <= '0;
      digest_q       <= '0;
      cnt_q          <= '0;
      len_q          <= '0;
      b_q            <= '0;
      r_q            <= '0;
      pad_idx_q      <= '0;
      final_q        <= 1'b0;
      digest_valid_q <= 1'b0;
      hash_err_q     <= 1'b0;
      msg_ready_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q        <= state_d;
      h_q            <= h_d;
      digest_q       <= digest_d;
      cnt_q          <= cnt_d;
      len_q          <= len_d;
      b_q            <= b_d;
      r_q            <= r_d;
      pad_idx_q      <= pad_idx_d;
      final_q        <= final_d;
      digest_valid_q <= digest_valid_d;
      hash_err_q     <= hash_err_d;
      msg_ready_q    <= msg_ready_d;
      busy_q         <= busy_d;
    end
  end

  assign msg_ready    = msg_ready_q;
  assign busy         = busy_q;
  assign digest       = digest_q;
  assign digest_valid = digest_valid_q;
  assign hash_err     = hash_err_q;

endmodule

// File: tb/tb_hash_stream_core.sv
`timescale 1ns/1ps
// Bench for hash_stream_core: a default instance (32/64/8) and a
// 64/16/1 instance, checked against an independent behavioural hash model.
module tb_hash_stream_core;

  logic clk;
  logic rst_n;

  logic        start_a, mv_a, mb_last_dummy, ml_a;
  logic [63:0] len_a;
  logic [7:0]  mb_a;
  logic        rdy_a, busy_a, dv_a, err_a;
  logic [31:0] digest_a;

  logic        start_b, mv_b, ml_b;
  logic [15:0] len_b;
  logic [7:0]  mb_b;
  logic        rdy_b, busy_b, dv_b, err_b;
  logic [63:0] digest_b;

  int checks = 0;
  int errors = 0;

  hash_stream_core dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .len_in(len_a),
    .msg_valid(mv_a), .msg_byte(mb_a), .msg_last(ml_a),
    .msg_ready(rdy_a), .busy(busy_a), .digest(digest_a),
    .digest_valid(dv_a), .hash_err(err_a)
  );

  hash_stream_core #(
    .DIGEST_W(64), .LEN_W(16), .ROUNDS(1), .IV(64'h0123456789ABCDEF)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .len_in(len_b),
    .msg_valid(mv_b), .msg_byte(mb_b), .msg_last(ml_b),
    .msg_ready(rdy_b), .busy(busy_b), .digest(digest_b),
    .digest_valid(dv_b), .hash_err(err_b)
  );

  // Clock held low until 20 ns so reset can be observed before any edge.
  initial begin
    clk = 1'b0;
    #20;
    forever begin
      clk = 1'b1; #5;
      clk = 1'b0; #5;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural reference: message bytes then cnt bytes LSB first.
  function automatic logic [127:0] model(input int nl, input int rounds, input int len_w,
                                         input logic [127:0] iv, input logic [7:0] m[$],
                                         input logic [63:0] cnt);
    logic [7:0]   h  [16];
    logic [7:0]   hn [16];
    logic [7:0]   seq[$];
    logic [127:0] res;
    logic [7:0]   t, x;
    int           s;
    for (int j = 0; j < nl; j++) h[j] = iv[8*j +: 8];
    seq = m;
    for (int k = 0; k < len_w/8; k++) seq.push_back(cnt[8*k +: 8]);
    foreach (seq[i]) begin
      for (int r = 0; r < rounds; r++) begin
        t = seq[i] ^ 8'(r);
        for (int j = 0; j < nl; j++) begin
          x     = h[(j+1) % nl] ^ t;
          s     = (j + r) % 8;
          hn[j] = 8'((int'(x) << s) | (int'(x) >> (8 - s))) + h[j];
        end
        for (int j = 0; j < nl; j++) h[j] = hn[j];
      end
    end
    res = '0;
    for (int j = 0; j < nl; j++) res[8*j +: 8] = h[j];
    return res;
  endfunction

  // Run one message through dut_a with msg_valid held high; report observations.
  task automatic drive_a(input logic [63:0] len, input logic [7:0] m[$], input int last_idx,
                         input bit pulse_start, output logic [31:0] dig, output logic err,
                         output int lat, output int rdy_n, output int busy_n,
                         output int dv_n, output int dv_edge, output int bad_gap);
    int idx, last_x, prev_x;
    bit seen;
    idx = 0; last_x = 0; prev_x = -1; seen = 0;
    dig = '0; err = 1'b0; lat = -1; rdy_n = 0; busy_n = 0; dv_n = 0; dv_edge = -1; bad_gap = 0;
    @(negedge clk);
    start_a = 1'b1; len_a = len;
    @(negedge clk);
    start_a = 1'b0; len_a = '0;
    for (int t = 0; t < 1000; t++) begin
      if (dv_a) begin
        dv_n++;
        if (!seen) begin
          seen = 1; dig = digest_a; err = err_a; dv_edge = t; lat = t - last_x;
        end
      end
      if (rdy_a)  rdy_n++;
      if (busy_a) busy_n++;
      start_a = 1'b0;
      if (pulse_start && busy_a && !rdy_a && (t % 17 == 5)) begin
        start_a = 1'b1; len_a = 64'd99;
      end
      if (idx < m.size()) begin
        mv_a = 1'b1; mb_a = m[idx]; ml_a = (idx == last_idx);
        if (rdy_a) begin
          if (prev_x >= 0 && (t + 1 - prev_x) != 9) bad_gap++;
          prev_x = t + 1; last_x = t + 1; idx++;
        end
      end else begin
        mv_a = 1'b0; ml_a = 1'b0; mb_a = 8'h00;
      end
      if (seen && t >= dv_edge + 4) break;
      @(negedge clk);
    end
    if (!seen) $display("FAIL drive_a_timeout: digest_valid never seen");
    start_a = 1'b0; mv_a = 1'b0; ml_a = 1'b0; len_a = '0;
  endtask

  // One-byte message on dut_b; lat counts edges from the transfer to digest_valid.
  task automatic run_b(output int lat, output logic [63:0] dig, output logic err,
                       output logic rdy0);
    lat = -1; dig = '0; err = 1'b0;
    @(negedge clk);
    start_b = 1'b1; len_b = 16'd1;
    @(negedge clk);
    start_b = 1'b0; len_b = '0;
    rdy0 = rdy_b;
    mv_b = 1'b1; mb_b = 8'h5A; ml_b = 1'b1;
    @(negedge clk);
    mv_b = 1'b0; ml_b = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (dv_b) begin
        lat = k; dig = digest_b; err = err_b;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #12.8;
    rst_n = 1'b0;
    #1;
    checks++; if (rdy_a !== 1'b0)     begin errors++; $display("FAIL rst_ready: got %b expected 0", rdy_a); end
    checks++; if (busy_a !== 1'b0)    begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_a); end
    checks++; if (dv_a !== 1'b0)      begin errors++; $display("FAIL rst_dv: got %b expected 0", dv_a); end
    checks++; if (err_a !== 1'b0)     begin errors++; $display("FAIL rst_err: got %b expected 0", err_a); end
    checks++; if (digest_a !== 32'h0) begin errors++; $display("FAIL rst_digest: got %h expected 0", digest_a); end
    checks++; if (dut_a.h_q !== 32'h0) begin errors++; $display("FAIL rst_h: got %h expected 0", dut_a.h_q); end
    checks++; if (dut_a.cnt_q !== 64'h0) begin errors++; $display("FAIL rst_cnt: got %h expected 0", dut_a.cnt_q); end
    checks++; if (dut_a.r_q !== 8'h0) begin errors++; $display("FAIL rst_r: got %h expected 0", dut_a.r_q); end
    checks++; if (digest_b !== 64'h0) begin errors++; $display("FAIL rst_digest_b: got %h expected 0", digest_b); end
    @(posedge clk);
    #1;
    checks++; if (busy_a !== 1'b0 || rdy_a !== 1'b0 || digest_a !== 32'h0)
      begin errors++; $display("FAIL rst_hold: busy %b ready %b digest %h expected all 0", busy_a, rdy_a, digest_a); end
    @(negedge clk);
    rst_n = 1'b1;
    // Message signals outside ABSORB must be ignored.
    mv_a = 1'b1; ml_a = 1'b1; mb_a = 8'hFF;
    repeat (3) @(negedge clk);
    checks++; if (busy_a !== 1'b0 || rdy_a !== 1'b0 || dv_a !== 1'b0 || err_a !== 1'b0)
      begin errors++; $display("FAIL idle_ignore: busy %b ready %b dv %b err %b expected all 0", busy_a, rdy_a, dv_a, err_a); end
    mv_a = 1'b0; ml_a = 1'b0; mb_a = 8'h00;
  endtask

  task automatic test_zero_len();
    logic [7:0]   q[$];
    logic [127:0] exp;
    logic [31:0]  dig;
    logic         err;
    int lat, rdy_n, busy_n, dv_n, dv_edge, bad_gap;
    q = {};
    exp = model(4, 8, 64, 128'(32'h3B6A2F91), q, 64'd0);
    drive_a(64'd0, q, -1, 1'b0, dig, err, lat, rdy_n, busy_n, dv_n, dv_edge, bad_gap);
    checks++; if (rdy_n !== 0)    begin errors++; $display("FAIL zero_ready: got %0d expected 0", rdy_n); end
    checks++; if (busy_n !== 64)  begin errors++; $display("FAIL zero_busy: got %0d expected 64", busy_n); end
    checks++; if (dv_n !== 1)     begin errors++; $display("FAIL zero_pulses: got %0d expected 1", dv_n); end
    checks++; if (dv_edge !== 64) begin errors++; $display("FAIL zero_latency: got %0d expected 64", dv_edge); end
    checks++; if (err !== 1'b0)   begin errors++; $display("FAIL zero_err: got %b expected 0", err); end
    checks++; if (dig !== exp[31:0]) begin errors++; $display("FAIL zero_digest: got %h expected %h", dig, exp[31:0]); end
  endtask

  task automatic test_stream15();
    logic [7:0]   q[$];
    logic [127:0] exp;
    logic [31:0]  dig;
    logic         err;
    int lat, rdy_n, busy_n, dv_n, dv_edge, bad_gap;
    q = {};
    for (int i = 0; i < 15; i++) q.push_back(8'(i));
    exp = model(4, 8, 64, 128'(32'h3B6A2F91), q, 64'd15);
    drive_a(64'd15, q, 14, 1'b0, dig, err, lat, rdy_n, busy_n, dv_n, dv_edge, bad_gap);
    checks++; if (rdy_n !== 15)  begin errors++; $display("FAIL s15_ready: got %0d expected 15", rdy_n); end
    checks++; if (bad_gap !== 0) begin errors++; $display("FAIL s15_gap: got %0d bad gaps expected 0", bad_gap); end
    checks++; if (lat !== 72)    begin errors++; $display("FAIL s15_latency: got %0d expected 72", lat); end
    checks++; if (dv_n !== 1)    begin errors++; $display("FAIL s15_pulses: got %0d expected 1", dv_n); end
    checks++; if (err !== 1'b0)  begin errors++; $display("FAIL s15_err: got %b expected 0", err); end
    checks++; if (dig !== exp[31:0]) begin errors++; $display("FAIL s15_digest: got %h expected %h", dig, exp[31:0]); end
  endtask

  task automatic test_early_last();
    logic [7:0]   q[$];
    logic [127:0] exp;
    logic [31:0]  dig;
    logic         err;
    int lat, rdy_n, busy_n, dv_n, dv_edge, bad_gap;
    q = {};
    q.push_back(8'hA5); q.push_back(8'h3C); q.push_back(8'h0F);
    exp = model(4, 8, 64, 128'(32'h3B6A2F91), q, 64'd3);
    drive_a(64'd4, q, 2, 1'b0, dig, err, lat, rdy_n, busy_n, dv_n, dv_edge, bad_gap);
    checks++; if (err !== 1'b1)  begin errors++; $display("FAIL early_err: got %b expected 1", err); end
    checks++; if (lat !== 72)    begin errors++; $display("FAIL early_latency: got %0d expected 72", lat); end
    checks++; if (dig !== exp[31:0]) begin errors++; $display("FAIL early_digest: got %h expected %h", dig, exp[31:0]); end
    checks++; if (err_a !== 1'b1 || digest_a !== exp[31:0] || dv_a !== 1'b0)
      begin errors++; $display("FAIL early_hold: err %b digest %h dv %b expected 1 %h 0", err_a, digest_a, dv_a, exp[31:0]); end
  endtask

  task automatic test_len_hit();
    logic [7:0]   q[$];
    logic [127:0] exp;
    logic [31:0]  dig;
    logic         err;
    int lat, rdy_n, busy_n, dv_n, dv_edge, bad_gap;
    q = {};
    q.push_back(8'h11); q.push_back(8'h22);
    exp = model(4, 8, 64, 128'(32'h3B6A2F91), q, 64'd2);
    drive_a(64'd2, q, -1, 1'b0, dig, err, lat, rdy_n, busy_n, dv_n, dv_edge, bad_gap);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL lenhit_err: got %b expected 1", err); end
    checks++; if (dig !== exp[31:0]) begin errors++; $display("FAIL lenhit_digest: got %h expected %h", dig, exp[31:0]); end
  endtask

  task automatic test_start_ignored();
    logic [7:0]   q[$];
    logic [127:0] exp;
    logic [31:0]  dig1, dig2;
    logic         err1, err2;
    int lat1, lat2, rdy_n, busy_n, dv_n1, dv_n2, dv_edge, bad_gap;
    q = {};
    q.push_back(8'hDE); q.push_back(8'hAD); q.push_back(8'hBE); q.push_back(8'hEF);
    exp = model(4, 8, 64, 128'(32'h3B6A2F91), q, 64'd4);
    drive_a(64'd4, q, 3, 1'b0, dig1, err1, lat1, rdy_n, busy_n, dv_n1, dv_edge, bad_gap);
    drive_a(64'd4, q, 3, 1'b1, dig2, err2, lat2, rdy_n, busy_n, dv_n2, dv_edge, bad_gap);
    checks++; if (dig1 !== exp[31:0]) begin errors++; $display("FAIL nostart_digest: got %h expected %h", dig1, exp[31:0]); end
    checks++; if (dig2 !== exp[31:0]) begin errors++; $display("FAIL pulsed_digest: got %h expected %h", dig2, exp[31:0]); end
    checks++; if (lat2 !== 72)   begin errors++; $display("FAIL pulsed_latency: got %0d expected 72", lat2); end
    checks++; if (dv_n2 !== 1 || err2 !== 1'b0)
      begin errors++; $display("FAIL pulsed_pulse_err: pulses %0d err %b expected 1 0", dv_n2, err2); end
  endtask

  task automatic test_param_b();
    logic [7:0]   q[$];
    logic [127:0] exp;
    logic [63:0]  dig;
    logic         err, rdy0;
    int lat, bad;
    q = {};
    q.push_back(8'h5A);
    exp = model(8, 1, 16, 128'(64'h0123456789ABCDEF), q, 64'd1);
    run_b(lat, dig, err, rdy0);
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL b_ready: got %b expected 1", rdy0); end
    checks++; if (lat !== 3)     begin errors++; $display("FAIL b_latency: got %0d expected 3", lat); end
    checks++; if (err !== 1'b0)  begin errors++; $display("FAIL b_err: got %b expected 0", err); end
    checks++; if (dig !== exp[63:0]) begin errors++; $display("FAIL b_digest: got %h expected %h", dig, exp[63:0]); end

    // Abort in PAD: transfer at E, ROUND at E+1, PAD after E+1.
    @(negedge clk);
    start_b = 1'b1; len_b = 16'd1;
    @(negedge clk);
    start_b = 1'b0; len_b = '0;
    mv_b = 1'b1; mb_b = 8'h5A; ml_b = 1'b1;
    @(negedge clk);
    mv_b = 1'b0; ml_b = 1'b0;
    @(negedge clk);
    checks++; if (busy_b !== 1'b1 || dv_b !== 1'b0)
      begin errors++; $display("FAIL b_in_pad: busy %b dv %b expected 1 0", busy_b, dv_b); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy_b !== 1'b0 || digest_b !== 64'h0 || dv_b !== 1'b0)
      begin errors++; $display("FAIL b_abort: busy %b digest %h dv %b expected 0 0 0", busy_b, digest_b, dv_b); end
    #1 rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (dv_b !== 1'b0 || busy_b !== 1'b0 || rdy_b !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b_wait_start: got %0d active cycles expected 0", bad); end
    run_b(lat, dig, err, rdy0);
    checks++; if (lat !== 3 || dig !== exp[63:0])
      begin errors++; $display("FAIL b_restart: latency %0d digest %h expected 3 %h", lat, dig, exp[63:0]); end
  endtask

  initial begin
    rst_n = 1'b1;
    start_a = 1'b0; len_a = '0; mv_a = 1'b0; mb_a = 8'h00; ml_a = 1'b0; mb_last_dummy = 1'b0;
    start_b = 1'b0; len_b = '0; mv_b = 1'b0; mb_b = 8'h00; ml_b = 1'b0;
    test_reset();
    test_zero_len();
    test_stream15();
    test_early_last();
    test_len_hit();
    test_start_ignored();
    test_param_b();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hash_stream_core.md
HASH_STREAM_CORE -- requirements
Module: hash_stream_core

Interface
REQ-001 Parameter DIGEST_W, default 32, is the digest width in bits; it SHALL be a multiple of 8 in 16..128, giving N = DIGEST_W/8 byte lanes.
REQ-002 Parameter LEN_W, default 64, is the length-field width in bits; it SHALL be a multiple of 8 in 8..64, giving P = LEN_W/8 padding bytes.
REQ-003 Parameter ROUNDS, default 8, is the number of rounds per absorbed byte; it SHALL be in 1..64.
REQ-004 Parameter IV, default 32'h3B6A2F91, width DIGEST_W, is the initial chaining value; lane j = IV[8j+7:8j].
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle request to begin a message; sampled only in IDLE or DONE.
REQ-008 len_in  in  LEN_W  declared message length in bytes; sampled with start.
REQ-009 msg_valid  in  1  msg_byte is valid this cycle.
REQ-010 msg_byte  in  8  message byte.
REQ-011 msg_last  in  1  qualifies msg_byte as the final byte.
REQ-012 msg_ready  out  1  core accepts a byte this cycle; a transfer occurs on msg_valid & msg_ready.
REQ-013 busy  out  1  high in ABSORB, ROUND and PAD.
REQ-014 digest  out  DIGEST_W  final chaining value; lane j at bits [8j+7:8j].
REQ-015 digest_valid  out  1  one-cycle pulse when digest is final.
REQ-016 hash_err  out  1  length mismatch flag; valid with digest_valid and held until the next accepted start.

Function
REQ-017 The FSM SHALL have the states IDLE, ABSORB, ROUND, PAD and DONE.
REQ-018 On start in IDLE or DONE, the core SHALL load h from IV, clear the byte counter cnt (LEN_W bits), clear hash_err and latch len_in; it SHALL then go to ABSORB, or to PAD if len_in==0.
REQ-019 msg_ready SHALL be 1 only in ABSORB; start SHALL be ignored in ABSORB, ROUND and PAD.
REQ-020 On a transfer, the core SHALL latch msg_byte into b, increment cnt modulo 2^LEN_W, clear the round counter r and enter ROUND.
REQ-021 Each ROUND cycle SHALL compute, for all j in parallel: t = b ^ r[7:0]; h'[j] = (rotl8(h[(j+1) mod N] ^ t, (j+r) mod 8) + h[j]) mod 256.
REQ-022 After round ROUNDS-1 of a message byte, the next state SHALL be PAD if that byte was final, otherwise ABSORB.
REQ-023 A byte SHALL be final if msg_last was high at its transfer or if cnt after increment equals the latched length.
REQ-024 hash_err SHALL be set at the final byte if exactly one of the two REQ-023 conditions holds.
REQ-025 PAD SHALL absorb the P bytes of cnt, least-significant byte first, each with ROUNDS rounds per REQ-021.
REQ-026 After the last PAD round, the core SHALL register digest = h, pulse digest_valid for one cycle and enter DONE; digest SHALL hold until the next start.
REQ-027 Latency: with the final byte transferred on edge E, h SHALL update on edges E+1 .. E+ROUNDS*(1+P), and digest_valid SHALL be high in the cycle after edge E+ROUNDS*(1+P). For defaults this is 72 edges.
REQ-028 With zero length and start on edge S, digest_valid SHALL be high after edge S+ROUNDS*P.
REQ-029 msg_valid, msg_byte and msg_last SHALL be ignored outside ABSORB; msg_last with msg_valid low SHALL have no effect.

Reset
REQ-030 While rst_n=0, the core SHALL be in IDLE with msg_ready=0, busy=0, digest_valid=0, hash_err=0, digest=0, h=0, cnt=0 and r=0, independent of clk.
REQ-031 A reset assertion mid-message SHALL abort immediately; after release the core SHALL wait for a new start.

Verification
REQ-032 Reset at 12.8 ns, with outputs checked before the first clock edge -> all REQ-030 values hold.
REQ-033 Defaults, start with len_in=0 -> msg_ready stays 0, busy=1 for 64 cycles, one digest_valid pulse, hash_err=0, and digest equals the golden model of IV over eight zero bytes.
REQ-034 Defaults, len_in=15, bytes 0..14 with msg_last on byte 14 and msg_valid held high -> msg_ready high exactly 1 cycle per 9, digest_valid 72 edges after the last transfer, hash_err=0, and digest matches the model.
REQ-035 Defaults, len_in=4 with msg_last on byte 2 -> finalisation pads cnt=3, hash_err=1, and digest equals the model of a 3-byte message.
REQ-036 start pulsed during ROUND and PAD -> ignored, and digest is unchanged versus the run without the pulses.
REQ-037 DIGEST_W=64, LEN_W=16, ROUNDS=1, 1-byte message -> digest_valid 3 edges after the transfer; rst_n pulsed low mid-PAD -> no digest_valid until a new start.
